// File: rtl/program_loader.sv
// Byte-stream front end for the instruction-memory loader: parses a 4-byte
// big-endian word count, then big-endian words, and paces the fetch-stage strobes.
module program_loader #(
    parameter int INST_MEM_WIDTH = 2
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [31:0]             input_data,
    output logic                    input_start,
    output logic                    input_valid,
    output logic                    input_end,
    output logic                    loading,
    output logic                    done,
    output logic                    error,
    output logic [INST_MEM_WIDTH:0] word_count
);

    localparam int CW = INST_MEM_WIDTH + 1;
    localparam logic [32:0] CAPACITY = 33'd1 << INST_MEM_WIDTH;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_HDR   = 4'd1;
    localparam logic [3:0] S_START = 4'd2;
    localparam logic [3:0] S_GAP   = 4'd3;
    localparam logic [3:0] S_DATA  = 4'd4;
    localparam logic [3:0] S_TAIL  = 4'd5;
    localparam logic [3:0] S_END   = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
    localparam logic [3:0] S_ERR   = 4'd8;

    logic [3:0]    state_reg;
    logic [3:0]    state_next;
    logic [1:0]    byte_idx_reg;
    logic [23:0]   shift_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] collected_reg;
    logic [CW-1:0] word_count_reg;
    logic [31:0]   data_reg;
    logic          valid_reg;
    logic          valid_next;
    logic          pending_reg;

    logic [31:0]   assembled;
    logic          hdr_phase;
    logic          data_phase;
    logic          hdr_accept;
    logic          hdr_first;
    logic          data_accept;
    logic          byte_last;
    logic          hdr_last;
    logic          word_last;
    logic          overflow;

    always_comb begin
        assembled   = {shift_reg, rx_data};
        hdr_phase   = (state_reg == S_IDLE) || (state_reg == S_HDR) || (state_reg == S_DONE);
        data_phase  = (state_reg == S_START) || (state_reg == S_GAP) || (state_reg == S_DATA);
        hdr_accept  = rx_valid && hdr_phase;
        hdr_first   = hdr_accept && (state_reg != S_HDR);
        // Bytes beyond the announced word count are not part of this image.
        data_accept = rx_valid && data_phase && (collected_reg < count_reg);
        byte_last   = (byte_idx_reg == 2'd3);
        hdr_last    = hdr_accept && (state_reg == S_HDR) && byte_last;
        word_last   = data_accept && byte_last;
        overflow    = {1'b0, assembled} > CAPACITY;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: if (rx_valid) state_next = S_HDR;
            S_HDR:          if (hdr_last) state_next = overflow ? S_ERR : S_START;
            S_START:        state_next = S_GAP;
            S_GAP:          state_next = (count_reg == '0) ? S_END : S_DATA;
            S_DATA:         if (valid_reg && (word_count_reg == count_reg)) state_next = S_TAIL;
            S_TAIL:         state_next = S_END;
            S_END:          state_next = S_DONE;
            S_ERR:          state_next = S_ERR;
            default:        state_next = S_IDLE;
        endcase
        // A word finished during START/GAP waits here until DATA, keeping the
        // fetch stage's two-cycle spacing after input_start.
        valid_next = (state_next == S_DATA) && (word_last || pending_reg);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            byte_idx_reg   <= 2'd0;
            shift_reg      <= '0;
            count_reg      <= '0;
            collected_reg  <= '0;
            word_count_reg <= '0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            pending_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            valid_reg   <= valid_next;
            pending_reg <= (pending_reg || word_last) && !valid_next;

            if (hdr_first) begin
                byte_idx_reg <= 2'd1;
            end else if (hdr_accept || data_accept) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
            end

            if (hdr_accept || data_accept) begin
                shift_reg <= {shift_reg[15:0], rx_data};
            end

            if (hdr_last) begin
                count_reg <= assembled[CW-1:0];
            end

            if (hdr_first) begin
                collected_reg <= '0;
            end else if (word_last) begin
                collected_reg <= collected_reg + 1'b1;
            end

            if (hdr_first) begin
                word_count_reg <= '0;
            end else if (valid_next) begin
                word_count_reg <= word_count_reg + 1'b1;
            end

            if (word_last) begin
                data_reg <= assembled;
            end
        end
    end

    assign input_data  = data_reg;
    assign input_start = (state_reg == S_START);
    assign input_valid = valid_reg;
    assign input_end   = (state_reg == S_END);
    assign loading     = (state_reg == S_HDR) || (state_reg == S_START) || (state_reg == S_GAP)
                      || (state_reg == S_DATA) || (state_reg == S_TAIL) || (state_reg == S_END);
    assign done        = (state_reg == S_DONE);
    assign error       = (state_reg == S_ERR);
    assign word_count  = word_count_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a timeline model derives every expected
// strobe/flag from the byte schedule and is compared against the DUT each cycle.
module tb_program_loader;

    localparam int     W    = 2;
    localparam int     MAXC = 128;
    localparam longint CAP  = 64'd1 << W;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] input_data;
    logic        input_start;
    logic        input_valid;
    logic        input_end;
    logic        loading;
    logic        done;
    logic        error;
    logic [W:0]  word_count;

    program_loader #(.INST_MEM_WIDTH(W)) dut (
        .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .input_data(input_data), .input_start(input_start), .input_valid(input_valid),
        .input_end(input_end), .loading(loading), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 CLK = ~CLK;

    bit          sv [MAXC];
    logic [7:0]  sb [MAXC];
    int          bc [$];
    logic [7:0]  bv [$];

    bit          e_start [MAXC];
    bit          e_valid [MAXC];
    bit          e_end [MAXC];
    bit          e_loading [MAXC];
    bit          e_done [MAXC];
    bit          e_error [MAXC];
    int          e_wc [MAXC];
    logic [31:0] e_data [MAXC];

    int          cyc;
    bit          checking;
    int          errors;
    int          checks;
    int          obs_start;
    int          obs_end;
    int          obs_v [$];
    logic [31:0] obs_d [$];
    int          c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_sched();
        for (int k = 0; k < MAXC; k++) begin
            sv[k] = 1'b0;
            sb[k] = 8'h00;
        end
        bc.delete();
        bv.delete();
        obs_v.delete();
        obs_d.delete();
        obs_start = -1;
        obs_end   = -1;
    endtask

    task automatic add_byte(input int at, input logic [7:0] b);
        sv[at] = 1'b1;
        sb[at] = b;
        bc.push_back(at);
        bv.push_back(b);
    endtask

    task automatic add_word(inout int at, input logic [31:0] w, input int sp);
        for (int k = 0; k < 4; k++) begin
            add_byte(at, w[31-8*k -: 8]);
            at += sp;
        end
    endtask

    // Timeline model: walks the byte list as headers and words, placing each
    // strobe at the cycle the timing rules give.
    task automatic build_model();
        int i, t, h0, endc, lastv, d, v, n;
        logic [31:0] val, wv;
        longint lv;
        for (int k = 0; k < MAXC; k++) begin
            e_start[k] = 0; e_valid[k] = 0; e_end[k] = 0;
            e_loading[k] = 0; e_done[k] = 0; e_error[k] = 0;
            e_wc[k] = 0; e_data[k] = '0;
        end
        i = 0;
        while (i + 3 < bc.size()) begin
            h0  = bc[i];
            t   = bc[i+3];
            val = {bv[i], bv[i+1], bv[i+2], bv[i+3]};
            i  += 4;
            for (int k = h0 + 1; k < MAXC; k++) begin
                e_done[k] = 0;
                e_wc[k]   = 0;
            end
            lv = longint'(val);
            if (lv > CAP) begin
                for (int k = h0 + 1; k <= t; k++) e_loading[k] = 1;
                for (int k = t + 1; k < MAXC; k++) e_error[k] = 1;
                break;
            end
            n = int'(val);
            e_start[t+1] = 1;
            lastv = t + 1;
            for (int w = 0; w < n; w++) begin
                if (i + 3 >= bc.size()) break;
                d  = bc[i+3];
                wv = {bv[i], bv[i+1], bv[i+2], bv[i+3]};
                i += 4;
                v  = (d + 1 > t + 3) ? d + 1 : t + 3;
                e_valid[v] = 1;
                e_data[v]  = wv;
                for (int k = v; k < MAXC; k++) e_wc[k] = w + 1;
                lastv = v;
            end
            endc = (n == 0) ? t + 3 : lastv + 2;
            e_end[endc] = 1;
            for (int k = h0 + 1; k <= endc; k++) e_loading[k] = 1;
            for (int k = endc + 1; k < MAXC; k++) e_done[k] = 1;
            while (i < bc.size() && bc[i] <= endc) i++;
        end
    endtask

    always @(negedge CLK) begin
        if (checking) begin
            chk("start",   32'(input_start), 32'(e_start[cyc]));
            chk("valid",   32'(input_valid), 32'(e_valid[cyc]));
            chk("end",     32'(input_end),   32'(e_end[cyc]));
            chk("loading", 32'(loading),     32'(e_loading[cyc]));
            chk("done",    32'(done),        32'(e_done[cyc]));
            chk("error",   32'(error),       32'(e_error[cyc]));
            chk("wcount",  32'(word_count),  32'(e_wc[cyc]));
            if (e_valid[cyc]) chk("data", input_data, e_data[cyc]);
            if (input_start) obs_start = cyc;
            if (input_end) obs_end = cyc;
            if (input_valid) begin
                obs_v.push_back(cyc);
                obs_d.push_back(input_data);
                $display("word cycle=%0d data=%h count=%0d", cyc, input_data, word_count);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_data"},  input_data, 32'h0);
        chk({tag, "_flags"}, 32'({input_start, input_valid, input_end, loading, done, error}), 32'h0);
        chk({tag, "_wc"},    32'(word_count), 32'h0);
    endtask

    task automatic do_reset();
        checking = 0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        check_zero("reset");
        @(negedge CLK);
        reset = 1'b1;
    endtask

    task automatic run_window(input int len);
        build_model();
        for (int k = 0; k < len; k++) begin
            @(posedge CLK);
            #1;
            cyc      = k;
            checking = 1;
            rx_valid = sv[k];
            rx_data  = sb[k];
        end
        @(posedge CLK);
        checking = 0;
        #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        checking = 0;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // N=2, all bytes back to back
        do_reset();
        clear_sched();
        c = 2;
        add_word(c, 32'd2, 1);
        add_word(c, 32'hDEADBEEF, 1);
        add_word(c, 32'h01234567, 1);
        run_window(20);
        chk("s1_start_cyc", obs_start, 6);
        chk("s1_nvalid", obs_v.size(), 2);
        if (obs_v.size() == 2) begin
            chk("s1_v0_cyc", obs_v[0], 10);
            chk("s1_v0_data", obs_d[0], 32'hDEADBEEF);
            chk("s1_v1_cyc", obs_v[1], 14);
            chk("s1_v1_data", obs_d[1], 32'h01234567);
            chk("s1_start_to_valid", obs_v[0] - obs_start, 4);
        end
        chk("s1_end_cyc", obs_end, 16);
        chk("s1_done", 32'(done), 1);
        chk("s1_wc", 32'(word_count), 2);

        // empty image
        do_reset();
        clear_sched();
        c = 1;
        add_word(c, 32'd0, 1);
        run_window(12);
        chk("s2_start_cyc", obs_start, 5);
        chk("s2_end_cyc", obs_end, 7);
        chk("s2_nvalid", obs_v.size(), 0);
        chk("s2_done", 32'(done), 1);

        // overflow, then a legal header that must be ignored
        do_reset();
        clear_sched();
        c = 1;
        add_word(c, 32'd5, 1);
        c = 10;
        add_word(c, 32'd4, 1);
        add_word(c, 32'hAAAA5555, 1);
        run_window(24);
        chk("s3_error", 32'(error), 1);
        chk("s3_no_start", obs_start, -1);
        chk("s3_no_end", obs_end, -1);
        chk("s3_nvalid", obs_v.size(), 0);
        chk("s3_loading", 32'(loading), 0);

        // full capacity after reset, bytes every other cycle
        do_reset();
        clear_sched();
        c = 1;
        add_word(c, 32'd4, 1);
        for (int k = 0; k < 4; k++) add_word(c, 32'h10203040 + 32'h01010101 * k, 2);
        run_window(42);
        chk("s4_nvalid", obs_v.size(), 4);
        if (obs_v.size() == 4) begin
            chk("s4_v3_cyc", obs_v[3], 36);
            chk("s4_v3_data", obs_d[3], 32'h13233343);
        end
        chk("s4_end_cyc", obs_end, 38);
        chk("s4_wc", 32'(word_count), 4);

        // asynchronous reset after the second word of N=4
        do_reset();
        clear_sched();
        c = 1;
        add_word(c, 32'd4, 1);
        add_word(c, 32'hA1B2C3D4, 1);
        add_word(c, 32'h0BADF00D, 1);
        add_word(c, 32'h55AA55AA, 1);
        run_window(15);
        chk("s5_nvalid", obs_v.size(), 2);
        chk("s5_loading_pre", 32'(loading), 1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("s5_async");

        // fresh N=1 load
        do_reset();
        clear_sched();
        c = 1;
        add_word(c, 32'd1, 1);
        add_word(c, 32'hFEEDFACE, 1);
        run_window(14);
        chk("s6_nvalid", obs_v.size(), 1);
        if (obs_v.size() == 1) chk("s6_data", obs_d[0], 32'hFEEDFACE);
        chk("s6_wc", 32'(word_count), 1);
        chk("s6_done", 32'(done), 1);

        // reload from DONE, with a stray byte during TAIL of the first load
        do_reset();
        clear_sched();
        c = 1;
        add_word(c, 32'd1, 1);
        add_word(c, 32'h11223344, 1);
        add_byte(10, 8'h99);
        c = 14;
        add_word(c, 32'd2, 1);
        add_word(c, 32'h55667788, 1);
        add_word(c, 32'h99AABBCC, 1);
        run_window(32);
        chk("s7_nvalid", obs_v.size(), 3);
        if (obs_v.size() == 3) begin
            chk("s7_v1_data", obs_d[1], 32'h55667788);
            chk("s7_v2_cyc", obs_v[2], 26);
            chk("s7_v2_data", obs_d[2], 32'h99AABBCC);
        end
        chk("s7_end_cyc", obs_end, 28);
        chk("s7_wc", 32'(word_count), 2);
        chk("s7_done", 32'(done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
